// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debouncer-side driver and the button event decoder.
// The master side drives the clean level; the slave (decoder) returns events.
interface button_event_decoder_if #(
   parameter int unsigned COUNT_WIDTH = 8
);
   logic                   debounced_in;
   logic                   press;
   logic                   release_evt;
   logic                   long_press;
   logic                   repeat_tick;
   logic                   holding;
   logic [COUNT_WIDTH-1:0] press_count;

   modport master (
      output debounced_in,
      input  press,
      input  release_evt,
      input  long_press,
      input  repeat_tick,
      input  holding,
      input  press_count
   );

   modport slave (
      input  debounced_in,
      output press,
      output release_evt,
      output long_press,
      output repeat_tick,
      output holding,
      output press_count
   );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/long-press/repeat
// pulses, a HELD level and a wrapping press counter. All outputs are registered.
module button_event_decoder #(
   parameter int unsigned LONG_TICKS   = 1000,
   parameter int unsigned REPEAT_TICKS = 250,
   parameter int unsigned COUNT_WIDTH  = 8
) (
   input logic                    clk,
   input logic                    rst,
   button_event_decoder_if.slave  bus
);
   localparam int unsigned MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int unsigned TIMER_W   = $clog2(MAX_TICKS) + 1;
   localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_TICKS - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_TICKS - 1);

   typedef enum logic [1:0] {StArming, StIdle, StPressed, StHeld} state_e;

   state_e                 state_q, state_d;
   logic [TIMER_W-1:0]     timer_q, timer_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q, long_d;
   logic                   repeat_q, repeat_d;
   logic                   holding_q, holding_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StArming;
         timer_q   <= '0;
         count_q   <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         holding_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         count_q   <= count_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         holding_q <= holding_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = '0;
      count_d   = count_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;

      unique case (state_q)
         // Wait for a low level so a button held through reset is never a press.
         StArming: begin
            if (!bus.debounced_in) state_d = StIdle;
         end
         StIdle: begin
            if (bus.debounced_in) begin
               state_d = StPressed;
               press_d = 1'b1;
               count_d = count_q + 1'b1;
            end
         end
         // Release is checked first so it wins over a simultaneous timer expiry.
         StPressed: begin
            if (!bus.debounced_in) begin
               state_d   = StIdle;
               release_d = 1'b1;
            end else if (timer_q == LONG_LAST) begin
               state_d = StHeld;
               long_d  = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StHeld: begin
            if (!bus.debounced_in) begin
               state_d   = StIdle;
               release_d = 1'b1;
            end else if (timer_q == REPEAT_LAST) begin
               repeat_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StArming;
      endcase

      holding_d = (state_d == StHeld);
   end

   assign bus.press       = press_q;
   assign bus.release_evt = release_q;
   assign bus.long_press  = long_q;
   assign bus.repeat_tick = repeat_q;
   assign bus.holding     = holding_q;
   assign bus.press_count = count_q;
endmodule
